// File: rtl/unified_mem_arbiter.sv
// Shared single-port memory arbiter between the instruction-fetch and data ports.
// Data wins by default; a starvation counter lets a waiting fetch through.
module unified_mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_byteen,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_byteen,
  input  logic [31:0] mem_rdata,
  output logic        dbg_state
);

  // Handshake: a requester holds req and payload until gnt is seen in the same
  // cycle; gnt is only ever raised at an arbitration point (IDLE or response cycle).
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [2:0] LAT  = 3'(MEM_LAT);
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  state_t     state;
  logic       owner_d;
  logic       wr;
  logic [2:0] cnt;
  logic [3:0] starve;

  logic resp;
  logic arb;
  logic gnt_i;
  logic gnt_d;
  logic addr_lsb_unused;

  assign addr_lsb_unused = ^{i_addr[1:0], d_addr[1:0]};

  // Every combinational output is qualified by reset so nothing leaks while it is low.
  always_comb begin
    resp  = reset && (state == BUSY) && (cnt == LAT);
    arb   = reset && ((state == IDLE) || resp);
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (arb) begin
      if (i_req && d_req && (starve >= SMAX)) gnt_i = 1'b1;
      else if (d_req)                         gnt_d = 1'b1;
      else if (i_req)                         gnt_i = 1'b1;
    end
  end

  always_comb begin
    i_gnt      = gnt_i;
    d_gnt      = gnt_d;
    mem_en     = gnt_i || gnt_d;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    mem_byteen = 4'd0;
    if (gnt_d) begin
      mem_addr   = {d_addr[31:2], 2'b00};
      mem_wdata  = d_wdata;
      mem_byteen = d_byteen;
    end else if (gnt_i) begin
      mem_addr   = {i_addr[31:2], 2'b00};
    end
    i_rvalid  = resp && !owner_d;
    d_rvalid  = resp && owner_d;
    i_rdata   = i_rvalid ? mem_rdata : 32'd0;
    d_rdata   = (d_rvalid && !wr) ? mem_rdata : 32'd0;
    dbg_state = (state == BUSY);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      owner_d <= 1'b0;
      wr      <= 1'b0;
      cnt     <= 3'd0;
      starve  <= 4'd0;
    end else begin
      if (gnt_i || gnt_d) begin
        state   <= BUSY;
        cnt     <= 3'd1;
        owner_d <= gnt_d;
        wr      <= gnt_d && (d_byteen != 4'd0);
      end else if (resp) begin
        state <= IDLE;
        cnt   <= 3'd0;
      end else if (state == BUSY) begin
        cnt <= cnt + 3'd1;
      end
      // Starvation only counts data wins that a live fetch request lost to.
      if (arb) begin
        if (gnt_i || !i_req)                starve <= 4'd0;
        else if (gnt_d && starve != 4'hF)   starve <= starve + 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Bench for unified_mem_arbiter: three instances (latency 2, 1, 3) share stimulus
// and are checked each cycle against a timestamp-based reference model.
module tb_unified_mem_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        i_req;
  logic [31:0] i_addr;
  logic        d_req;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_byteen;
  logic [31:0] mem_rdata;

  logic        i_gnt_v[3];
  logic        i_rvalid_v[3];
  logic [31:0] i_rdata_v[3];
  logic        d_gnt_v[3];
  logic        d_rvalid_v[3];
  logic [31:0] d_rdata_v[3];
  logic        mem_en_v[3];
  logic [31:0] mem_addr_v[3];
  logic [31:0] mem_wdata_v[3];
  logic [3:0]  mem_byteen_v[3];
  logic        dbg_v[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT_G = (g == 0) ? 2 : ((g == 1) ? 1 : 3);
    unified_mem_arbiter #(.MEM_LAT(LAT_G), .STARVE_MAX(3)) u_dut (
      .clk        (clk),
      .reset      (reset),
      .i_req      (i_req),
      .i_addr     (i_addr),
      .i_gnt      (i_gnt_v[g]),
      .i_rvalid   (i_rvalid_v[g]),
      .i_rdata    (i_rdata_v[g]),
      .d_req      (d_req),
      .d_addr     (d_addr),
      .d_wdata    (d_wdata),
      .d_byteen   (d_byteen),
      .d_gnt      (d_gnt_v[g]),
      .d_rvalid   (d_rvalid_v[g]),
      .d_rdata    (d_rdata_v[g]),
      .mem_en     (mem_en_v[g]),
      .mem_addr   (mem_addr_v[g]),
      .mem_wdata  (mem_wdata_v[g]),
      .mem_byteen (mem_byteen_v[g]),
      .mem_rdata  (mem_rdata),
      .dbg_state  (dbg_v[g])
    );
  end

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Each instance remembers when its outstanding response is due, not a counter.
  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 3);
  endfunction

  int cyc = 0;
  bit m_busy[3];
  int m_resp[3];
  bit m_owner_d[3];
  bit m_wr[3];
  int m_starve[3];
  bit n_busy[3];
  int n_resp[3];
  bit n_owner_d[3];
  bit n_wr[3];
  int n_starve[3];

  task automatic sample();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      bit resp, arb, wi, wd, e_irv, e_drv;
      logic [31:0] e_addr, e_wdata, e_ird, e_drd;
      logic [3:0] e_be;
      resp = (reset === 1'b1) && m_busy[k] && (cyc == m_resp[k]);
      arb  = (reset === 1'b1) && (!m_busy[k] || resp);
      wi = 1'b0;
      wd = 1'b0;
      if (arb) begin
        if (i_req && d_req && m_starve[k] >= 3) wi = 1'b1;
        else if (d_req) wd = 1'b1;
        else if (i_req) wi = 1'b1;
      end
      e_addr = 32'd0;
      e_wdata = 32'd0;
      e_be = 4'd0;
      if (wd) begin
        e_addr = {d_addr[31:2], 2'b00};
        e_wdata = d_wdata;
        e_be = d_byteen;
      end else if (wi) begin
        e_addr = {i_addr[31:2], 2'b00};
      end
      e_irv = resp && !m_owner_d[k];
      e_drv = resp && m_owner_d[k];
      e_ird = e_irv ? mem_rdata : 32'd0;
      e_drd = (e_drv && !m_wr[k]) ? mem_rdata : 32'd0;
      chk($sformatf("i_gnt[%0d]", k), 32'(i_gnt_v[k]), 32'(wi));
      chk($sformatf("d_gnt[%0d]", k), 32'(d_gnt_v[k]), 32'(wd));
      chk($sformatf("mem_en[%0d]", k), 32'(mem_en_v[k]), 32'(wi | wd));
      chk($sformatf("mem_addr[%0d]", k), mem_addr_v[k], e_addr);
      chk($sformatf("mem_wdata[%0d]", k), mem_wdata_v[k], e_wdata);
      chk($sformatf("mem_byteen[%0d]", k), 32'(mem_byteen_v[k]), 32'(e_be));
      chk($sformatf("i_rvalid[%0d]", k), 32'(i_rvalid_v[k]), 32'(e_irv));
      chk($sformatf("d_rvalid[%0d]", k), 32'(d_rvalid_v[k]), 32'(e_drv));
      if (e_irv || reset !== 1'b1) chk($sformatf("i_rdata[%0d]", k), i_rdata_v[k], e_ird);
      if (e_drv || reset !== 1'b1) chk($sformatf("d_rdata[%0d]", k), d_rdata_v[k], e_drd);
      chk($sformatf("dbg_state[%0d]", k), 32'(dbg_v[k]), 32'((reset === 1'b1) && m_busy[k]));
      n_busy[k] = m_busy[k];
      n_resp[k] = m_resp[k];
      n_owner_d[k] = m_owner_d[k];
      n_wr[k] = m_wr[k];
      n_starve[k] = m_starve[k];
      if (reset !== 1'b1) begin
        n_busy[k] = 1'b0;
        n_resp[k] = 0;
        n_owner_d[k] = 1'b0;
        n_wr[k] = 1'b0;
        n_starve[k] = 0;
      end else begin
        if (wi || wd) begin
          n_busy[k] = 1'b1;
          n_resp[k] = cyc + lat_of(k);
          n_owner_d[k] = wd;
          n_wr[k] = wd && (d_byteen != 4'd0);
        end else if (resp) begin
          n_busy[k] = 1'b0;
        end
        if (arb) begin
          if (wi || !i_req) n_starve[k] = 0;
          else if (wd) n_starve[k] = (m_starve[k] >= 15) ? 15 : m_starve[k] + 1;
        end
      end
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 3; k++) begin
      m_busy[k] = n_busy[k];
      m_resp[k] = n_resp[k];
      m_owner_d[k] = n_owner_d[k];
      m_wr[k] = n_wr[k];
      m_starve[k] = n_starve[k];
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic ir, input logic [31:0] ia, input logic dr,
                       input logic [31:0] da, input logic [31:0] dw, input logic [3:0] be,
                       input logic [31:0] mr);
    i_req = ir;
    i_addr = ia;
    d_req = dr;
    d_addr = da;
    d_wdata = dw;
    d_byteen = be;
    mem_rdata = mr;
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) begin
      drive(1'b0, 32'd0, 1'b0, 32'd0, 32'd0, 4'd0, 32'd0);
      sample();
      advance();
    end
  endtask

  // ---------------- directed vectors for the latency-2 instance ----------------
  typedef struct {
    logic        i_req;
    logic [31:0] i_addr;
    logic        d_req;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_byteen;
    logic [31:0] mem_rdata;
    logic        e_i_gnt;
    logic        e_d_gnt;
    logic [31:0] e_mem_addr;
    logic [31:0] e_mem_wdata;
    logic [3:0]  e_be;
    logic        e_i_rv;
    logic        e_d_rv;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[11];
  logic [0:0] exp_q[$];

  initial begin
    vecs[0]  = '{1'b1, 32'h3004, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                 1'b1, 1'b0, 32'h3004, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'hDEAD0001,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h2408000A,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h2408000A};
    vecs[3]  = '{1'b0, 32'h0, 1'b1, 32'h7, 32'hAB000000, 4'b1000, 32'h0,
                 1'b0, 1'b1, 32'h4, 32'hAB000000, 4'b1000, 1'b0, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vecs[5]  = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h12345678,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h0, 1'b1, 32'h100, 32'h0, 4'h0, 32'h0,
                 1'b0, 1'b1, 32'h100, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vecs[7]  = '{1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vecs[8]  = '{1'b1, 32'h200, 1'b0, 32'h0, 32'h0, 4'h0, 32'hCAFEF00D,
                 1'b1, 1'b0, 32'h200, 32'h0, 4'h0, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[9]  = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h11112222,
                 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0, 32'h11112222};

    // Reset state with requests pending: all outputs must stay low.
    reset = 1'b0;
    drive(1'b1, 32'h40, 1'b1, 32'h80, 32'h55, 4'hF, 32'hFFFFFFFF);
    for (int c = 0; c < 2; c++) begin
      sample();
      chk("rst_i_gnt", 32'(i_gnt_v[0]), 32'd0);
      chk("rst_mem_en", 32'(mem_en_v[0]), 32'd0);
      advance();
    end
    reset = 1'b1;

    for (int v = 0; v < 11; v++) begin
      drive(vecs[v].i_req, vecs[v].i_addr, vecs[v].d_req, vecs[v].d_addr,
            vecs[v].d_wdata, vecs[v].d_byteen, vecs[v].mem_rdata);
      sample();
      chk($sformatf("vec%0d_i_gnt", v), 32'(i_gnt_v[0]), 32'(vecs[v].e_i_gnt));
      chk($sformatf("vec%0d_d_gnt", v), 32'(d_gnt_v[0]), 32'(vecs[v].e_d_gnt));
      chk($sformatf("vec%0d_mem_en", v), 32'(mem_en_v[0]), 32'(vecs[v].e_i_gnt | vecs[v].e_d_gnt));
      chk($sformatf("vec%0d_mem_addr", v), mem_addr_v[0], vecs[v].e_mem_addr);
      chk($sformatf("vec%0d_mem_wdata", v), mem_wdata_v[0], vecs[v].e_mem_wdata);
      chk($sformatf("vec%0d_mem_byteen", v), 32'(mem_byteen_v[0]), 32'(vecs[v].e_be));
      chk($sformatf("vec%0d_i_rvalid", v), 32'(i_rvalid_v[0]), 32'(vecs[v].e_i_rv));
      chk($sformatf("vec%0d_d_rvalid", v), 32'(d_rvalid_v[0]), 32'(vecs[v].e_d_rv));
      if (vecs[v].e_i_rv) chk($sformatf("vec%0d_i_rdata", v), i_rdata_v[0], vecs[v].e_rdata);
      if (vecs[v].e_d_rv) chk($sformatf("vec%0d_d_rdata", v), d_rdata_v[0], vecs[v].e_rdata);
      advance();
    end

    // Both ports held high: grant order must follow D,D,D,I repeating.
    idle(4);
    for (int r = 0; r < 2; r++) begin
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
    end
    drive(1'b1, 32'h1000, 1'b1, 32'h2000, 32'h0, 4'h0, 32'h0);
    for (int c = 0; c < 40; c++) begin
      mem_rdata = $urandom;
      sample();
      if ((i_gnt_v[0] || d_gnt_v[0]) && exp_q.size() > 0) begin
        chk("starve_order", 32'(d_gnt_v[0]), 32'(exp_q.pop_front()));
      end
      advance();
    end
    chk("starve_grants_seen", 32'(exp_q.size()), 32'd0);

    // Back-to-back reads on the latency-1 instance.
    idle(4);
    for (int j = 0; j < 4; j++) begin
      drive(1'b0, 32'h0, 1'b1, 32'h40 * (j + 1), 32'h0, 4'h0, $urandom);
      sample();
      chk($sformatf("b2b%0d_d_gnt", j), 32'(d_gnt_v[1]), 32'd1);
      chk($sformatf("b2b%0d_mem_addr", j), mem_addr_v[1], 32'h40 * (j + 1));
      chk($sformatf("b2b%0d_d_rvalid", j), 32'(d_rvalid_v[1]), 32'(j > 0));
      advance();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
    sample();
    chk("b2b_tail_d_rvalid", 32'(d_rvalid_v[1]), 32'd1);
    chk("b2b_tail_d_gnt", 32'(d_gnt_v[1]), 32'd0);
    advance();

    // Late fetch while the latency-3 instance is busy.
    idle(4);
    drive(1'b0, 32'h0, 1'b1, 32'h80, 32'h0, 4'h0, 32'h0);
    sample();
    chk("late_d_gnt", 32'(d_gnt_v[2]), 32'd1);
    advance();
    for (int c = 1; c < 4; c++) begin
      drive(1'b1, 32'h300, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      sample();
      chk($sformatf("late_c%0d_i_gnt", c), 32'(i_gnt_v[2]), 32'(c == 3));
      chk($sformatf("late_c%0d_d_rvalid", c), 32'(d_rvalid_v[2]), 32'(c == 3));
      advance();
    end

    // Reset dropped mid-access on the latency-2 instance.
    idle(4);
    drive(1'b0, 32'h0, 1'b1, 32'h50, 32'h12345678, 4'hF, 32'h0);
    sample();
    chk("rstmid_d_gnt", 32'(d_gnt_v[0]), 32'd1);
    advance();
    for (int c = 1; c < 7; c++) begin
      if (c == 1) reset = 1'b0;
      if (c == 3) reset = 1'b1;
      if (c == 1 || c == 2) drive(1'b1, 32'h60, 1'b1, 32'h70, 32'h0, 4'h1, 32'hA5A5A5A5);
      else if (c == 4) drive(1'b1, 32'h60, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      else drive(1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 4'h0, 32'h0);
      sample();
      chk($sformatf("rstmid_c%0d_d_rvalid", c), 32'(d_rvalid_v[0]), 32'd0);
      if (c < 3) begin
        chk($sformatf("rstmid_c%0d_mem_en", c), 32'(mem_en_v[0]), 32'd0);
        chk($sformatf("rstmid_c%0d_mem_addr", c), mem_addr_v[0], 32'd0);
        chk($sformatf("rstmid_c%0d_gnts", c), 32'({i_gnt_v[0], d_gnt_v[0]}), 32'd0);
      end
      if (c == 4) chk("rstmid_c4_i_gnt", 32'(i_gnt_v[0]), 32'd1);
      advance();
    end

    // Random traffic with occasional resets, checked by the model only.
    for (int c = 0; c < 600; c++) begin
      reset = ($urandom_range(0, 63) == 0) ? 1'b0 : 1'b1;
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom,
            $urandom, ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15)),
            $urandom);
      sample();
      advance();
    end
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
